// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM channel arbiter.
// Request record, channel ids, FSM encoding and the watchdog fill word.
package sdram_arb_pkg;

  localparam int NCH = 3;

  localparam logic [1:0] CH_DL      = 2'd0;
  localparam logic [1:0] CH_ROM     = 2'd1;
  localparam logic [1:0] CH_SAVE    = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic        rnw;
    logic [26:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
  } arb_req_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: request channel between the arbiter and the SDRAM ctrl.
// master = arbiter side, slave = SDRAM controller side.
interface sdram_arbiter_if;

  logic        sdram_ena;
  logic        sdram_rnw;
  logic [26:0] sdram_Adr;
  logic [3:0]  sdram_be;
  logic [31:0] sdram_dataWrite;
  logic        sdram_done;
  logic [31:0] sdram_dataRead;

  modport master (
    output sdram_ena,
    output sdram_rnw,
    output sdram_Adr,
    output sdram_be,
    output sdram_dataWrite,
    input  sdram_done,
    input  sdram_dataRead
  );

  modport slave (
    input  sdram_ena,
    input  sdram_rnw,
    input  sdram_Adr,
    input  sdram_be,
    input  sdram_dataWrite,
    output sdram_done,
    output sdram_dataRead
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr: combinational winner select over three pending channels.
// Search starts after ptr (last grant); PRIO0 lets ch0 pre-empt the search.
module sdram_arb_rr
  import sdram_arb_pkg::*;
#(
  parameter bit PRIO0 = 1'b1
) (
  input  logic [NCH-1:0] pending,
  input  logic [1:0]     ptr,
  output logic [1:0]     winner,
  output logic           valid
);

  logic [1:0] c0, c1, c2;

  // Search order: the three channels rotated to start after ptr
  always_comb begin
    c0 = CH_DL;
    c1 = CH_ROM;
    c2 = CH_SAVE;
    unique case (ptr)
      CH_DL: begin
        c0 = CH_ROM;
        c1 = CH_SAVE;
        c2 = CH_DL;
      end
      CH_ROM: begin
        c0 = CH_SAVE;
        c1 = CH_DL;
        c2 = CH_ROM;
      end
      default: ;
    endcase
  end

  // First pending channel in search order, ch0 first when prioritised
  always_comb begin
    winner = GRANT_NONE;
    valid  = |pending;
    if (PRIO0 && pending[CH_DL]) winner = CH_DL;
    else if (pending[c0])        winner = c0;
    else if (pending[c1])        winner = c1;
    else if (pending[c2])        winner = c2;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM request channel between three requesters.
// Optional watchdog: define SDRAM_ARB_TIMEOUT_EN (adds timeout_err port).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter bit          PRIO0   = 1'b1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk1x,
  input  logic        reset,
  input  logic [2:0]  ch_req,
  input  logic [2:0]  ch_rnw,
  input  logic [80:0] ch_addr,
  input  logic [95:0] ch_din,
  input  logic [11:0] ch_be,
  output logic [2:0]  ch_ready,
  output logic [31:0] ch_dout,
  sdram_arbiter_if.master sdram,
  output logic        busy,
  output logic [1:0]  grant_id
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  arb_state_t     state_q, state_d;
  logic [NCH-1:0] pend_q, clr, cap;
  arb_req_t       hold_q [NCH];
  logic [1:0]     ptr_q, win;
  logic           win_vld, go, fin, tmo_hit;
  logic [31:0]    fin_data;

  sdram_arb_rr #(
    .PRIO0(PRIO0)
  ) u_rr (
    .pending(pend_q),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_vld)
  );

  // Completion frees the owner's slot; a pulse in that cycle refills it
  always_comb begin
    clr = '0;
    if (fin) clr = 3'b001 << grant_id;
    cap = ch_req & (~pend_q | clr);
  end

  // Next state: grant from IDLE, finish on done or watchdog
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_WAIT;
          go      = 1'b1;
        end
      end
      S_WAIT: begin
        if (sdram.sdram_done || tmo_hit) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Pending bits and per-channel holding registers
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      for (int n = 0; n < NCH; n++) hold_q[n] <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | cap;
      for (int n = 0; n < NCH; n++) begin
        if (cap[n]) begin
          hold_q[n].rnw  <= ch_rnw[n];
          hold_q[n].addr <= ch_addr[27*n +: 27];
          hold_q[n].din  <= ch_din[32*n +: 32];
          hold_q[n].be   <= ch_be[4*n +: 4];
        end
      end
    end
  end

  // Registered SDRAM request, grant bookkeeping and completion return
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      sdram.sdram_ena       <= 1'b0;
      sdram.sdram_rnw       <= 1'b0;
      sdram.sdram_Adr       <= '0;
      sdram.sdram_be        <= '0;
      sdram.sdram_dataWrite <= '0;
      ch_ready              <= '0;
      ch_dout               <= '0;
      busy                  <= 1'b0;
      grant_id              <= GRANT_NONE;
      ptr_q                 <= 2'd0;
    end else begin
      sdram.sdram_ena <= go;
      ch_ready        <= clr;
      if (go) begin
        sdram.sdram_rnw       <= hold_q[win].rnw;
        sdram.sdram_Adr       <= hold_q[win].addr;
        sdram.sdram_be        <= hold_q[win].be;
        sdram.sdram_dataWrite <= hold_q[win].din;
        grant_id              <= win;
        busy                  <= 1'b1;
        ptr_q                 <= win;
      end
      if (fin) begin
        ch_dout  <= fin_data;
        grant_id <= GRANT_NONE;
        busy     <= 1'b0;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  // Watchdog fires on the TIMEOUT-th WAIT edge without done
  always_comb begin
    tmo_hit  = (state_q == S_WAIT) && !sdram.sdram_done &&
               (tmo_cnt == 10'(TIMEOUT - 1));
    fin_data = tmo_hit ? TIMEOUT_DATA : sdram.sdram_dataRead;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (go)                       tmo_cnt <= '0;
      else if (state_q == S_WAIT)   tmo_cnt <= tmo_cnt + 10'd1;
      if (tmo_hit)                  timeout_err <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  // No watchdog: WAIT only ends on done
  always_comb begin
    tmo_hit    = 1'b0;
    fin_data   = sdram.sdram_dataRead;
    unused_tmo = (TIMEOUT == 0) ^ TIMEOUT_DATA[0];
  end
`endif

  req_overrun: assert property (
    @(posedge clk1x) disable iff (reset)
    !(|(ch_req & pend_q & ~clr))
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench, u[0] PRIO0=1 and u[1] round-robin.
// Each u[g] has its own SDRAM responder; expectations queued at stimulus.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  logic clk1x = 1'b0;
  always #5 clk1x = ~clk1x;

  logic reset;
  logic [1:0][2:0]  ch_req, ch_rnw, ch_ready;
  logic [1:0][80:0] ch_addr;
  logic [1:0][95:0] ch_din;
  logic [1:0][11:0] ch_be;
  logic [1:0][31:0] ch_dout, dw_w;
  logic [1:0][1:0]  gid;
  logic [1:0]       busy, ena_w, rnw_w;
  logic [1:0][26:0] adr_w;
  logic [1:0][3:0]  be_w;
  logic [1:0]       mdl_on, tmo_mode;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [1:0]       tmo_err;
`endif

  arb_req_t exp_q [6][$];
  int       order_q [2][$];
  int       served [2][3];
  int       n_vec = 0;
  int       n_err = 0;

  task automatic check(input int g, input string tag,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL u%0d.%s: got %h, expected %h", g, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [26:0] a);
    return 32'h12345678 ^ {5'd0, a ^ 27'h0800010};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    sdram_arbiter_if bus ();
    logic        m_done = 1'b0;
    logic        m_pend = 1'b0;
    logic [1:0]  m_cnt  = 2'd0;
    logic [26:0] m_adr  = '0;
    logic [31:0] m_data = '0;
    logic        cur_v  = 1'b0;
    logic [1:0]  cur_ch = 2'd0;
    arb_req_t    cur;

    sdram_arbiter #(
      .PRIO0  (g == 0),
      .TIMEOUT(20)
    ) dut (
      .clk1x   (clk1x),
      .reset   (reset),
      .ch_req  (ch_req[g]),
      .ch_rnw  (ch_rnw[g]),
      .ch_addr (ch_addr[g]),
      .ch_din  (ch_din[g]),
      .ch_be   (ch_be[g]),
      .ch_ready(ch_ready[g]),
      .ch_dout (ch_dout[g]),
      .sdram   (bus),
      .busy    (busy[g]),
      .grant_id(gid[g])
`ifdef SDRAM_ARB_TIMEOUT_EN
      ,
      .timeout_err(tmo_err[g])
`endif
    );

    assign bus.sdram_done     = m_done;
    assign bus.sdram_dataRead = m_data;
    assign ena_w[g] = bus.sdram_ena;
    assign rnw_w[g] = bus.sdram_rnw;
    assign adr_w[g] = bus.sdram_Adr;
    assign be_w[g]  = bus.sdram_be;
    assign dw_w[g]  = bus.sdram_dataWrite;

    // SDRAM responder: done pulse a few cycles after ena, not reset
    always @(posedge clk1x) begin
      m_done <= 1'b0;
      if (bus.sdram_ena) begin
        m_pend <= 1'b1;
        m_cnt  <= 2'd2;
        m_adr  <= bus.sdram_Adr;
      end else if (m_pend) begin
        if (!mdl_on[g]) m_pend <= 1'b0;
        else if (m_cnt == 2'd0) begin
          m_done <= 1'b1;
          m_data <= mdata(m_adr);
          m_pend <= 1'b0;
        end else m_cnt <= m_cnt - 2'd1;
      end
    end

    // Monitor: grants, held request fields, completions
    initial begin : mon
      logic saw_done;
      int   ech;
      saw_done = 1'b0;
      forever begin
        @(negedge clk1x);
        if (reset) begin
          cur_v    = 1'b0;
          saw_done = 1'b0;
          order_q[g].delete();
          for (int c = 0; c < 3; c++) exp_q[3*g+c].delete();
        end else begin
          if (saw_done)
            check(g, "rdy_lat", 32'(ch_ready[g] != 3'b000), 32'd1);
          if (ch_ready[g] != 3'b000) begin
            check(g, "rdy_expected", 32'(cur_v), 32'd1);
            if (cur_v) begin
              check(g, "rdy_mask", 32'(ch_ready[g]),
                    32'(3'b001 << cur_ch));
              check(g, "dout", ch_dout[g],
                    tmo_mode[g] ? TIMEOUT_DATA : mdata(cur.addr));
              check(g, "gid_free", 32'(gid[g]), 32'd3);
              check(g, "busy_free", 32'(busy[g]), 32'd0);
              void'(exp_q[3*g+int'(cur_ch)].pop_front());
              served[g][cur_ch]++;
              cur_v = 1'b0;
            end
          end
          saw_done = bus.sdram_done && cur_v;
          if (saw_done) begin
            check(g, "hold_adr", 32'(bus.sdram_Adr), 32'(cur.addr));
            check(g, "hold_dw", bus.sdram_dataWrite, cur.din);
            check(g, "hold_be", 32'(bus.sdram_be), 32'(cur.be));
            check(g, "hold_rnw", 32'(bus.sdram_rnw), 32'(cur.rnw));
          end
          if (bus.sdram_ena) begin
            check(g, "ena_expected", 32'(order_q[g].size() != 0), 32'd1);
            if (order_q[g].size() != 0) begin
              ech = order_q[g].pop_front();
              check(g, "grant", 32'(gid[g]), 32'(ech));
              check(g, "busy", 32'(busy[g]), 32'd1);
              check(g, "ena_req", 32'(exp_q[3*g+ech].size() != 0), 32'd1);
              if (exp_q[3*g+ech].size() != 0) begin
                cur    = exp_q[3*g+ech][0];
                cur_ch = 2'(ech);
                cur_v  = 1'b1;
                check(g, "adr", 32'(bus.sdram_Adr), 32'(cur.addr));
                check(g, "rnw", 32'(bus.sdram_rnw), 32'(cur.rnw));
                check(g, "be", 32'(bus.sdram_be), 32'(cur.be));
                check(g, "dw", bus.sdram_dataWrite, cur.din);
              end
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk1x);
    #1;
  endtask

  task automatic post(input int g, input int c, input logic rnw,
                      input logic [26:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    arb_req_t r;
    ch_req[g][c]           = 1'b1;
    ch_rnw[g][c]           = rnw;
    ch_addr[g][27*c +: 27] = a;
    ch_din[g][32*c +: 32]  = d;
    ch_be[g][4*c +: 4]     = be;
    r.rnw  = rnw;
    r.addr = a;
    r.din  = d;
    r.be   = be;
    exp_q[3*g+c].push_back(r);
  endtask

  task automatic drain(input int g);
    int t;
    t = 0;
    while ((exp_q[3*g].size() + exp_q[3*g+1].size() +
            exp_q[3*g+2].size()) != 0 && t < 500) begin
      step();
      t++;
    end
    check(g, "drain", 32'(t < 500), 32'd1);
    step();
  endtask

  task automatic reset_vals(input int g);
    check(g, "rst_ena", 32'(ena_w[g]), 32'd0);
    check(g, "rst_busy", 32'(busy[g]), 32'd0);
    check(g, "rst_gid", 32'(gid[g]), 32'd3);
    check(g, "rst_rdy", 32'(ch_ready[g]), 32'd0);
    check(g, "rst_dout", ch_dout[g], 32'd0);
    check(g, "rst_adr", 32'(adr_w[g]), 32'd0);
    check(g, "rst_dw", dw_w[g], 32'd0);
    check(g, "rst_be", 32'(be_w[g]), 32'd0);
    check(g, "rst_rnw", 32'(rnw_w[g]), 32'd0);
`ifdef SDRAM_ARB_TIMEOUT_EN
    check(g, "rst_tmo", 32'(tmo_err[g]), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t, issued, rc;
    ch_req   = '0;
    ch_rnw   = '0;
    ch_addr  = '0;
    ch_din   = '0;
    ch_be    = '0;
    mdl_on   = 2'b11;
    tmo_mode = 2'b00;
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < 3; c++) served[g][c] = 0;
    reset = 1'b1;
    step();
    step();
    for (int g = 0; g < 2; g++) reset_vals(g);
    reset = 1'b0;
    step();

    // single read on ch1, with request-to-ena latency
    post(0, 1, 1'b1, 27'h0800010, 32'h0, 4'hF);
    order_q[0].push_back(1);
    step();
    ch_req[0] = '0;
    check(0, "lat_early", 32'(ena_w[0]), 32'd0);
    step();
    check(0, "lat_ena", 32'(ena_w[0]), 32'd1);
    drain(0);
    check(0, "read_data", ch_dout[0], 32'h12345678);

    // ch0 priority: all three at once
    post(0, 0, 1'b1, 27'h0000100, 32'h0, 4'hF);
    post(0, 1, 1'b0, 27'h0000200, 32'h11112222, 4'hF);
    post(0, 2, 1'b1, 27'h0000300, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) order_q[0].push_back(i);
    step();
    ch_req[0] = '0;
    drain(0);

    // ch0 re-requests while ch1 is served
    post(0, 0, 1'b1, 27'h0001100, 32'h0, 4'hF);
    post(0, 1, 1'b1, 27'h0001200, 32'h0, 4'hF);
    post(0, 2, 1'b0, 27'h0001300, 32'h33334444, 4'hC);
    order_q[0].push_back(0);
    order_q[0].push_back(1);
    order_q[0].push_back(0);
    order_q[0].push_back(2);
    step();
    ch_req[0] = '0;
    t = 0;
    while (gid[0] != 2'd1 && t < 200) begin
      step();
      t++;
    end
    check(0, "wait_ch1", 32'(gid[0]), 32'd1);
    post(0, 0, 1'b0, 27'h0001400, 32'h55556666, 4'h3);
    step();
    ch_req[0] = '0;
    drain(0);

    // write path on ch2
    post(0, 2, 1'b0, 27'h3ABCDE0, 32'hAABBCCDD, 4'b0011);
    order_q[0].push_back(2);
    step();
    ch_req[0] = '0;
    drain(0);

    // reset in the middle of a ch1 access, late done follows
    post(0, 1, 1'b1, 27'h0400100, 32'h0, 4'hF);
    order_q[0].push_back(1);
    step();
    ch_req[0] = '0;
    step();
    check(0, "abort_ena", 32'(ena_w[0]), 32'd1);
    step();
    reset = 1'b1;
    #1;
    reset_vals(0);
    step();
    reset = 1'b0;
    repeat (8) step();
    check(0, "abort_idle", 32'(busy[0]), 32'd0);
    check(0, "abort_gid", 32'(gid[0]), 32'd3);
    post(0, 0, 1'b1, 27'h0000040, 32'h0, 4'hF);
    order_q[0].push_back(0);
    step();
    ch_req[0] = '0;
    drain(0);

    // round-robin on u[1]: 30 accesses, everyone re-requests
    for (int k = 0; k < 10; k++) begin
      order_q[1].push_back(1);
      order_q[1].push_back(2);
      order_q[1].push_back(0);
    end
    issued = 0;
    for (int c = 0; c < 3; c++) begin
      post(1, c, c[0], 27'(c * 27'h100000), 32'(c) * 32'h01010101, 4'hF);
      issued++;
    end
    step();
    ch_req[1] = '0;
    t = 0;
    while ((issued < 30 || (exp_q[3].size() + exp_q[4].size() +
            exp_q[5].size()) != 0) && t < 3000) begin
      step();
      t++;
      ch_req[1] = '0;
      if (ch_ready[1] != 3'b000 && issued < 30) begin
        rc = 0;
        for (int c = 0; c < 3; c++) if (ch_ready[1][c]) rc = c;
        post(1, rc, issued[0], 27'(rc * 27'h100000 + issued * 4),
             32'(issued) ^ 32'hA5A50000, 4'(issued));
        issued++;
      end
    end
    check(1, "rr_done", 32'(t < 3000), 32'd1);
    step();
    step();
    for (int c = 0; c < 3; c++)
      check(1, $sformatf("rr_served%0d", c), 32'(served[1][c]), 32'd10);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // watchdog: responder silent, ch2 completes with the fill word
    check(0, "tmo_before", 32'(tmo_err[0]), 32'd0);
    mdl_on[0]   = 1'b0;
    tmo_mode[0] = 1'b1;
    post(0, 2, 1'b1, 27'h0002000, 32'h0, 4'hF);
    order_q[0].push_back(2);
    step();
    ch_req[0] = '0;
    step();
    check(0, "tmo_ena", 32'(ena_w[0]), 32'd1);
    t = 0;
    while (ch_ready[0] == 3'b000 && t < 100) begin
      step();
      t++;
    end
    check(0, "tmo_cycles", 32'(t), 32'd20);
    check(0, "tmo_rdy", 32'(ch_ready[0]), 32'b100);
    check(0, "tmo_dout", ch_dout[0], 32'hDEADBEEF);
    check(0, "tmo_err", 32'(tmo_err[0]), 32'd1);
    drain(0);
    repeat (5) step();
    check(0, "tmo_sticky", 32'(tmo_err[0]), 32'd1);
    mdl_on[0]   = 1'b1;
    tmo_mode[0] = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM request channel (sdram_ena / sdram_done handshake, 27-bit byte address, 32-bit data) between three requesters:
  - ch0: cart download writer.
  - ch1: n64top ROM/PI reads.
  - ch2: save memory (SRAM/Flash) and savestate traffic.
- Sits between n64top/download logic and the sdram controller, all on clk1x.
- Latches single-cycle request pulses, arbitrates, issues one access at a time, and routes the completion back to the owner.

Parameters:
- PRIO0, 1, 1 = ch0 has strict priority over ch1/ch2; 0 = all three channels round-robin.
- TIMEOUT, 1023, watchdog cycle limit for one access (used only with the optional feature).

Ports:
- clk1x  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_req  in  3  per-channel request pulse, one cycle
- ch_rnw  in  3  per-channel access type: 1 = read, 0 = write
- ch_addr  in  81  3x27 byte address; ch n at [27n+26:27n]
- ch_din  in  96  3x32 write data
- ch_be  in  12  3x4 byte enables
- ch_ready  out  3  per-channel completion pulse, one cycle
- ch_dout  out  32  read data, valid in the ch_ready cycle
- sdram_ena  out  1  request pulse to SDRAM
- sdram_rnw  out  1  access type to SDRAM
- sdram_Adr  out  27  address to SDRAM
- sdram_be  out  4  byte enables to SDRAM
- sdram_dataWrite  out  32  write data to SDRAM
- sdram_done  in  1  completion pulse from SDRAM
- sdram_dataRead  in  32  read data from SDRAM
- busy  out  1  access outstanding (state WAIT)
- grant_id  out  2  channel currently owning SDRAM; 3 = none

Behaviour:
- Reset values: all outputs 0, except grant_id = 3. All pending bits cleared. Round-robin pointer = 0. State = IDLE.
- Request capture:
  - ch_req[n] at an edge with pending[n] = 0 → pending[n] = 1; rnw/addr/din/be copied into holding register n.
  - ch_req[n] while pending[n] = 1 is ignored; this is a protocol violation, flagged by an assertion.
- State machine, two states:
  - IDLE: if any pending bit is set, select a winner and go to WAIT. In the same edge, register sdram_ena = 1 for exactly one cycle, drive sdram_rnw/Adr/be/dataWrite from holding register[winner], and set grant_id = winner, busy = 1.
  - WAIT: hold sdram_rnw/Adr/be/dataWrite stable. On sdram_done: next edge ch_ready[grant] = 1 for one cycle, ch_dout = sdram_dataRead (written even for writes), pending[grant] cleared, grant_id = 3, busy = 0, state returns to IDLE.
- Latency:
  - Request pulse sampled at edge k → sdram_ena high in the cycle after edge k+1, if the channel wins.
  - sdram_done sampled at edge j → ch_ready after edge j. Minimum two cycles between sdram_ena pulses.
- Arbitration:
  - PRIO0 = 1: ch0 wins whenever pending; ch1/ch2 round-robin.
  - PRIO0 = 0: round-robin over all three.
  - The round-robin search starts at the channel after the last granted one; the pointer updates on grant.
- Simultaneous events:
  - ch_req[n] in the same cycle as the edge that clears pending[n] (ch_ready edge) is captured as a new request.
  - A request arriving in the same edge the arbiter selects is not considered until the next IDLE.
- sdram_done while IDLE is ignored: no ch_ready, no state change.
- Reset mid-access aborts it: no ch_ready; pending bits lost. A late sdram_done after reset is ignored because state is IDLE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A 10-bit counter runs in WAIT. When it reaches TIMEOUT without sdram_done, the access completes as if done arrived: ch_ready pulse with ch_dout = 32'hDEADBEEF.
  - A sticky output, timeout_err (1 bit, reset 0), is set on timeout.
  - The counter clears on entering WAIT.
- Undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package sdram_arb_pkg:
  - Typedef for the request record {rnw, addr[26:0], din[31:0], be[3:0]}.
  - Localparams NCH = 3, CH_DL = 0, CH_ROM = 1, CH_SAVE = 2, GRANT_NONE = 3, TIMEOUT_DATA = 32'hDEADBEEF.
- One sub-module, sdram_arb_rr: pure round-robin selector (pending, pointer, PRIO0 → winner, valid), instantiated once.

Test Plan:
- Single read: ch1 req, addr 0x0800010; SDRAM model returns 0x12345678 three cycles after ena → one ena pulse, Adr 0x0800010, rnw 1; ch_ready = 3'b010 one cycle; ch_dout = 0x12345678; grant_id returns to 3.
- Priority, PRIO0 = 1: ch0, ch1, ch2 req in the same cycle → grant order 0,1,2. ch0 re-requests while ch1 is served → order 0,1,0,2.
- Round-robin, PRIO0 = 0: all channels re-request continuously for 30 accesses → each channel served 10 times ±0; no channel twice in a row while others pend.
- Write path: ch2 req, be 4'b0011, din 0xAABBCCDD, rnw 0 → sdram_be 0011, sdram_dataWrite 0xAABBCCDD held stable until done; ch_ready[2] pulses.
- Reset mid-access: reset while WAIT for ch1, then sdram_done two cycles later → all outputs at reset values; no ch_ready; next ch0 req served normally.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT = 20: never assert done → ch_ready after 20 WAIT cycles; ch_dout = 0xDEADBEEF; timeout_err = 1 and remains 1.
